// File: rtl/prio_drain_arbiter.sv
// Packet-granular arbiter draining NUM_PRIO packet FIFOs into one SRAM write port; grant locks until eop.
// Latency: grant in IDLE, first pop next cycle, registered word one cycle after each pop.
// Backpressure: sram_ready low stalls pops with grant held. Define PRIO_DRAIN_ARBITER_RR_EN for round-robin.
module prio_drain_arbiter #(
  parameter int NUM_PRIO      = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_PKT_WORDS = 64,
  localparam int PW = (NUM_PRIO > 1) ? $clog2(NUM_PRIO) : 1,
  localparam int CW = $clog2(MAX_PKT_WORDS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PRIO-1:0]            q_ready,
  input  logic [NUM_PRIO-1:0]            q_sop,
  input  logic [NUM_PRIO-1:0]            q_eop,
  input  logic [NUM_PRIO*DATA_WIDTH-1:0] q_data,
  output logic [NUM_PRIO-1:0]            q_pop,
  input  logic                           sram_ready,
  output logic                           out_sop,
  output logic                           out_eop,
  output logic                           out_vld,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [PW-1:0]                  out_prio,
  output logic                           busy,
  output logic                           pkt_err
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         grant, winner;
  logic [CW-1:0]         cnt;
  logic                  pop, w_sop, w_eop, sop_err, trunc, pkt_end;
  logic [DATA_WIDTH-1:0] w_data;
  logic [DATA_WIDTH-1:0] head [NUM_PRIO];

`ifdef PRIO_DRAIN_ARBITER_RR_EN
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] idx;
`endif

  for (genvar i = 0; i < NUM_PRIO; i++) begin : g_head
    assign head[i] = q_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Descending scan so the lowest index (or offset from the pointer) wins.
  always_comb begin
    winner = '0;
`ifdef PRIO_DRAIN_ARBITER_RR_EN
    idx = '0;
    for (int k = NUM_PRIO - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_PRIO);
      if (q_ready[idx]) winner = idx;
    end
`else
    for (int i = NUM_PRIO - 1; i >= 0; i--) begin
      if (q_ready[PW'(i)]) winner = PW'(i);
    end
`endif
  end

  always_comb begin
    w_sop     = q_sop[grant];
    w_eop     = q_eop[grant];
    w_data    = head[grant];
    pop       = (state == XFER) && sram_ready && q_ready[grant];
    sop_err   = pop && (cnt == '0) && !w_sop;
    // The word that fills the packet to the limit closes it even without eop.
    trunc     = pop && !sop_err && !w_eop && (cnt == CW'(MAX_PKT_WORDS - 1));
    pkt_end   = pop && (sop_err || w_eop || trunc);
    q_pop     = '0;
    if (pop) q_pop[grant] = 1'b1;
    state_nxt = state;
    case (state)
      IDLE:    if (|q_ready) state_nxt = XFER;
      XFER:    if (pkt_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      cnt      <= '0;
      out_vld  <= 1'b0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      out_data <= '0;
      pkt_err  <= 1'b0;
`ifdef PRIO_DRAIN_ARBITER_RR_EN
      rr_ptr   <= '0;
`endif
    end else begin
      state   <= state_nxt;
      out_vld <= 1'b0;
      pkt_err <= 1'b0;
      if (state == IDLE && |q_ready) begin
        grant <= winner;
        cnt   <= '0;
      end
      if (pop) begin
        if (sop_err) begin
          pkt_err <= 1'b1;
        end else begin
          out_vld  <= 1'b1;
          out_data <= w_data;
          out_sop  <= w_sop;
          out_eop  <= w_eop | trunc;
          pkt_err  <= trunc;
        end
        cnt <= pkt_end ? '0 : cnt + 1'b1;
      end
`ifdef PRIO_DRAIN_ARBITER_RR_EN
      if (pkt_end) rr_ptr <= (grant == PW'(NUM_PRIO - 1)) ? '0 : grant + 1'b1;
`endif
    end
  end

  assign busy     = (state == XFER);
  assign out_prio = grant;

endmodule

// File: tb/tb_prio_drain_arbiter.sv
// Bench for prio_drain_arbiter: queue-based FIFO bank, cycle model checked every cycle, plus literal checks.
module tb_prio_drain_arbiter;
  localparam int NP = 8;
  localparam int DW = 16;
  localparam int MW = 4;
  localparam int PW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    q_ready, q_sop, q_eop, q_pop;
  logic [NP*DW-1:0] q_data;
  logic             sram_ready;
  logic             out_sop, out_eop, out_vld, busy, pkt_err;
  logic [DW-1:0]    out_data;
  logic [PW-1:0]    out_prio;

  always #5 clk = ~clk;

  prio_drain_arbiter #(.NUM_PRIO(NP), .DATA_WIDTH(DW), .MAX_PKT_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .q_ready(q_ready), .q_sop(q_sop), .q_eop(q_eop), .q_data(q_data),
    .q_pop(q_pop), .sram_ready(sram_ready), .out_sop(out_sop), .out_eop(out_eop),
    .out_vld(out_vld), .out_data(out_data), .out_prio(out_prio), .busy(busy), .pkt_err(pkt_err)
  );

  typedef struct packed {logic sop; logic eop; logic [DW-1:0] data;} word_t;
  typedef struct packed {
    logic vld; logic sop; logic eop; logic err; logic busy;
    logic [PW-1:0] prio; logic [DW-1:0] data; logic [NP-1:0] pop;
  } rec_t;

  word_t fifo [NP][$];
  rec_t  tr [int];
  int    n_chk = 0, n_fail = 0, cyc = 0;

  // Reference model state: what the registered outputs must be after the last edge.
  bit          m_known = 1'b0, m_xfer = 1'b0;
  int          m_g = 0, m_cnt = 0;
  logic        m_vld = 1'b0, m_sop = 1'b0, m_eop = 1'b0, m_err = 1'b0;
  logic [DW-1:0] m_data = '0;
`ifdef PRIO_DRAIN_ARBITER_RR_EN
  int          m_rr = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_heads();
    for (int i = 0; i < NP; i++) begin
      if (fifo[i].size() > 0) begin
        q_ready[i] = 1'b1;
        q_sop[i]   = fifo[i][0].sop;
        q_eop[i]   = fifo[i][0].eop;
        q_data[i*DW +: DW] = fifo[i][0].data;
      end else begin
        q_ready[i] = 1'b0;
        q_sop[i]   = 1'b0;
        q_eop[i]   = 1'b0;
        q_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic push_word(input int q, input logic s, input logic e, input logic [DW-1:0] d);
    word_t w;
    w.sop = s; w.eop = e; w.data = d;
    fifo[q].push_back(w);
  endtask

  task automatic push_pkt(input int q, input int n, input logic [DW-1:0] base);
    for (int w = 0; w < n; w++) push_word(q, w == 0, w == n - 1, base + DW'(w));
  endtask

  function automatic int pick();
    int r;
    r = -1;
`ifdef PRIO_DRAIN_ARBITER_RR_EN
    for (int k = 0; k < NP; k++)
      if (r < 0 && fifo[(m_rr + k) % NP].size() > 0) r = (m_rr + k) % NP;
`else
    for (int i = 0; i < NP; i++)
      if (r < 0 && fifo[i].size() > 0) r = i;
`endif
    return r;
  endfunction

  // One clock: compare at negedge, advance the model, then apply pops after the edge.
  task automatic step();
    logic [NP-1:0] pops, exp_pop;
    rec_t  r;
    word_t w;
    @(negedge clk);
    exp_pop = '0;
    if (m_xfer && sram_ready && fifo[m_g].size() > 0) exp_pop[m_g] = 1'b1;
    if (m_known) begin
      chk("out_vld",  32'(out_vld),  32'(m_vld));
      chk("out_sop",  32'(out_sop),  32'(m_sop));
      chk("out_eop",  32'(out_eop),  32'(m_eop));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("pkt_err",  32'(pkt_err),  32'(m_err));
      chk("busy",     32'(busy),     32'(m_xfer));
      chk("out_prio", 32'(out_prio), 32'(m_g));
      chk("q_pop",    32'(q_pop),    32'(exp_pop));
    end
    r.vld = out_vld; r.sop = out_sop; r.eop = out_eop; r.err = pkt_err; r.busy = busy;
    r.prio = out_prio; r.data = out_data; r.pop = q_pop;
    tr[cyc] = r;
    pops = q_pop;
    if (rst) begin
      m_known = 1'b1; m_xfer = 1'b0; m_g = 0; m_cnt = 0;
      m_vld = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_err = 1'b0; m_data = '0;
`ifdef PRIO_DRAIN_ARBITER_RR_EN
      m_rr = 0;
`endif
    end else begin
      m_vld = 1'b0;
      m_err = 1'b0;
      if (!m_xfer) begin
        if (pick() >= 0) begin
          m_g = pick(); m_xfer = 1'b1; m_cnt = 0;
        end
      end else if (exp_pop != '0) begin
        w = fifo[m_g][0];
        if (m_cnt == 0 && !w.sop) begin
          m_err = 1'b1; m_xfer = 1'b0;
`ifdef PRIO_DRAIN_ARBITER_RR_EN
          m_rr = (m_g + 1) % NP;
`endif
        end else begin
          m_cnt++;
          m_vld = 1'b1; m_data = w.data; m_sop = w.sop;
          m_eop = w.eop || (m_cnt == MW);
          m_err = !w.eop && (m_cnt == MW);
          if (m_eop) begin
            m_xfer = 1'b0; m_cnt = 0;
`ifdef PRIO_DRAIN_ARBITER_RR_EN
            m_rr = (m_g + 1) % NP;
`endif
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++)
      if (pops[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
    cyc++;
    drive_heads();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int c0, total;
    int order[$];
    rst = 1'b1; sram_ready = 1'b1; drive_heads();
    run(2);
    rst = 1'b0;
    run(2);
    c0 = cyc - 1;
    chk("rst_vld", 32'(tr[c0].vld), 32'd0);
    chk("rst_busy", 32'(tr[c0].busy), 32'd0);
    chk("rst_pop", 32'(tr[c0].pop), 32'd0);

    // Single 4-word packet on queue 3.
    c0 = cyc;
    push_pkt(3, 4, 16'h3000); drive_heads();
    run(8);
    chk("t1_pre_vld", 32'(tr[c0+1].vld), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("t1_vld", 32'(tr[c0+2+k].vld), 32'd1);
      chk("t1_data", 32'(tr[c0+2+k].data), 32'h3000 + 32'(k));
    end
    chk("t1_prio", 32'(tr[c0+2].prio), 32'd3);
    chk("t1_sop", 32'(tr[c0+2].sop), 32'd1);
    chk("t1_eop", 32'(tr[c0+5].eop), 32'd1);
    chk("t1_busy_in", 32'(tr[c0+4].busy), 32'd1);
    chk("t1_busy_out", 32'(tr[c0+5].busy), 32'd0);
    chk("t1_post_vld", 32'(tr[c0+6].vld), 32'd0);

    // Queues 5 and 1 together.
    c0 = cyc;
    push_pkt(5, 3, 16'h5000); push_pkt(1, 2, 16'h1000); drive_heads();
    run(10);
`ifndef PRIO_DRAIN_ARBITER_RR_EN
    chk("t2_first_prio", 32'(tr[c0+2].prio), 32'd1);
    chk("t2_first_data", 32'(tr[c0+2].data), 32'h1000);
    chk("t2_first_eop", 32'(tr[c0+3].eop), 32'd1);
    chk("t2_bubble", 32'(tr[c0+4].vld), 32'd0);
    chk("t2_second_prio", 32'(tr[c0+5].prio), 32'd5);
    chk("t2_second_data", 32'(tr[c0+5].data), 32'h5000);
    chk("t2_second_eop", 32'(tr[c0+7].data), 32'h5002);
`endif

    // Queue 0 arrives while queue 6 is mid-packet; queue 0 packet carries a mid-packet sop.
    c0 = cyc;
    push_pkt(6, 4, 16'h6000); drive_heads();
    run(3);
    push_word(0, 1'b1, 1'b0, 16'h0A00);
    push_word(0, 1'b1, 1'b0, 16'h0A01);
    push_word(0, 1'b0, 1'b1, 16'h0A02);
    drive_heads();
    run(9);
    chk("t3_hold_prio", 32'(tr[c0+4].prio), 32'd6);
    chk("t3_hold_data", 32'(tr[c0+4].data), 32'h6002);
    chk("t3_q6_eop", 32'(tr[c0+5].eop), 32'd1);
    chk("t3_q0_prio", 32'(tr[c0+7].prio), 32'd0);
    chk("t3_q0_data", 32'(tr[c0+7].data), 32'h0A00);
    chk("t3_mid_sop", 32'(tr[c0+8].sop), 32'd1);
    chk("t3_mid_err", 32'(tr[c0+8].err), 32'd0);

    // Three-cycle sram_ready stall after the first word of queue 2.
    c0 = cyc;
    push_pkt(2, 4, 16'h2000); drive_heads();
    for (int k = 0; k < 11; k++) begin
      if (k == 2) sram_ready = 1'b0;
      if (k == 5) sram_ready = 1'b1;
      step();
    end
    for (int k = 2; k < 5; k++) chk("t4_stall_pop", 32'(tr[c0+k].pop), 32'd0);
    for (int k = 3; k < 6; k++) chk("t4_stall_vld", 32'(tr[c0+k].vld), 32'd0);
    chk("t4_stall_prio", 32'(tr[c0+4].prio), 32'd2);
    chk("t4_stall_hold", 32'(tr[c0+4].data), 32'h2000);
    chk("t4_resume", 32'(tr[c0+6].data), 32'h2001);
    chk("t4_last", 32'(tr[c0+8].data), 32'h2003);
    chk("t4_last_eop", 32'(tr[c0+8].eop), 32'd1);

    // 6-word packet against a 4-word limit.
    c0 = cyc;
    push_pkt(4, 6, 16'h4000); drive_heads();
    run(12);
    chk("t5_pre_err", 32'(tr[c0+4].err), 32'd0);
    chk("t5_trunc_data", 32'(tr[c0+5].data), 32'h4003);
    chk("t5_trunc_eop", 32'(tr[c0+5].eop), 32'd1);
    chk("t5_trunc_err", 32'(tr[c0+5].err), 32'd1);
    chk("t5_regrant_pop", 32'(tr[c0+6].pop), 32'h10);
    chk("t5_discard_vld", 32'(tr[c0+7].vld), 32'd0);
    chk("t5_discard_err", 32'(tr[c0+7].err), 32'd1);
    chk("t5_second_err", 32'(tr[c0+9].err), 32'd1);

    // Reset in the middle of a queue 7 packet.
    c0 = cyc;
    push_pkt(7, 4, 16'h7000); drive_heads();
    run(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(8);
    chk("t6_pre_data", 32'(tr[c0+3].data), 32'h7001);
    chk("t6_rst_vld", 32'(tr[c0+4].vld), 32'd0);
    chk("t6_rst_busy", 32'(tr[c0+4].busy), 32'd0);
    chk("t6_rst_data", 32'(tr[c0+4].data), 32'd0);
    chk("t6_rst_prio", 32'(tr[c0+4].prio), 32'd0);
    chk("t6_rst_pop", 32'(tr[c0+4].pop), 32'd0);
    chk("t6_rst_eop", 32'(tr[c0+4].eop), 32'd0);
    chk("t6_leftover_err", 32'(tr[c0+6].err), 32'd1);

    // Queues 0 and 2 both holding two packets.
    c0 = cyc;
    push_pkt(0, 2, 16'h0B00); push_pkt(0, 2, 16'h0B10);
    push_pkt(2, 2, 16'h2B00); push_pkt(2, 2, 16'h2B10);
    drive_heads();
    run(16);
    for (int c = c0; c < c0 + 16; c++)
      if (tr[c].vld && tr[c].sop) order.push_back(int'(tr[c].prio));
    chk("t7_pkts", 32'(order.size()), 32'd4);
    if (order.size() == 4) begin
`ifdef PRIO_DRAIN_ARBITER_RR_EN
      chk("t7_order0", 32'(order[0]), 32'd0);
      chk("t7_order1", 32'(order[1]), 32'd2);
      chk("t7_order2", 32'(order[2]), 32'd0);
      chk("t7_order3", 32'(order[3]), 32'd2);
`else
      chk("t7_order0", 32'(order[0]), 32'd0);
      chk("t7_order1", 32'(order[1]), 32'd0);
      chk("t7_order2", 32'(order[2]), 32'd2);
      chk("t7_order3", 32'(order[3]), 32'd2);
`endif
    end

    total = 0;
    for (int i = 0; i < NP; i++) total += fifo[i].size();
    chk("drained", 32'(total), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
